// File: rtl/xtal_rtc_timebase.sv
// rtl/xtal_rtc_timebase.sv - crystal start-up qualifier, 1 Hz prescaler, 32-bit seconds counter and alarm
module xtal_rtc_timebase #(
  parameter int XTAL_FREQ      = 32768,
  parameter int PRESCALE_W     = 15,
  parameter int STARTUP_CYCLES = 4096,
  parameter int STARTUP_W      = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        xtal_ok,
  output logic        tick_1hz,
  output logic [31:0] sec_count,
  input  logic        sec_load,
  input  logic [31:0] sec_load_val,
  input  logic        alarm_en,
  input  logic [31:0] alarm_val,
  output logic        alarm,
  input  logic        alarm_clr
);

  localparam logic [PRESCALE_W-1:0] PRESC_TC     = PRESCALE_W'(XTAL_FREQ - 1);
  localparam logic [STARTUP_W-1:0]  STARTUP_LAST = STARTUP_W'(STARTUP_CYCLES - 1);

  logic [STARTUP_W-1:0]  r_startup_cnt;
  logic                  r_xtal_ok;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  r_tick;
  logic [31:0]           r_sec_count;
  logic                  r_alarm;

  logic                  w_wrap;
  logic                  w_tick_inc;
  logic [31:0]           w_sec_inc;
  logic                  w_alarm_set;

  // A load on the wrap edge swallows that tick, so neither the count nor the alarm sees it.
  always_comb begin
    w_wrap      = r_xtal_ok && (r_presc == PRESC_TC);
    w_tick_inc  = w_wrap && !sec_load;
    w_sec_inc   = r_sec_count + 32'd1;
    w_alarm_set = w_tick_inc && alarm_en && (w_sec_inc == alarm_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_startup_cnt <= '0;
      r_xtal_ok     <= 1'b0;
    end else if (!r_xtal_ok) begin
      r_startup_cnt <= r_startup_cnt + 1'b1;
      r_xtal_ok     <= (r_startup_cnt == STARTUP_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (sec_load || !r_xtal_ok || w_wrap) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick      <= 1'b0;
      r_sec_count <= '0;
    end else begin
      r_tick <= w_tick_inc;
      if (sec_load) begin
        r_sec_count <= sec_load_val;
      end else if (w_tick_inc) begin
        r_sec_count <= w_sec_inc;
      end
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
    end else if (w_alarm_set) begin
      r_alarm <= 1'b1;
    end else if (alarm_clr) begin
      r_alarm <= 1'b0;
    end
  end

  assign xtal_ok   = r_xtal_ok;
  assign tick_1hz  = r_tick;
  assign sec_count = r_sec_count;
  assign alarm     = r_alarm;

endmodule

// File: tb/tb_xtal_rtc_timebase.sv
// tb/tb_xtal_rtc_timebase.sv - directed self-checking bench for xtal_rtc_timebase
module tb_xtal_rtc_timebase;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        xtal_ok;
  logic        tick_1hz;
  logic [31:0] sec_count;
  logic        sec_load = 1'b0;
  logic [31:0] sec_load_val = '0;
  logic        alarm_en = 1'b0;
  logic [31:0] alarm_val = '0;
  logic        alarm;
  logic        alarm_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        xok;
    logic        tick;
    logic [31:0] sec;
  } vec_t;

  vec_t vecs [20];

  always #5 clk = ~clk;

  xtal_rtc_timebase #(
    .XTAL_FREQ(4), .PRESCALE_W(2), .STARTUP_CYCLES(8), .STARTUP_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .xtal_ok(xtal_ok), .tick_1hz(tick_1hz),
    .sec_count(sec_count), .sec_load(sec_load), .sec_load_val(sec_load_val),
    .alarm_en(alarm_en), .alarm_val(alarm_val), .alarm(alarm), .alarm_clr(alarm_clr)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] v);
    sec_load     = 1'b1;
    sec_load_val = v;
    step();
    sec_load     = 1'b0;
  endtask

  task automatic run_startup_table();
    for (int e = 0; e < 20; e++) begin
      step();
      chk($sformatf("s1_xok_e%0d", e + 1), {31'd0, xtal_ok}, {31'd0, vecs[e].xok});
      chk($sformatf("s1_tick_e%0d", e + 1), {31'd0, tick_1hz}, {31'd0, vecs[e].tick});
      chk($sformatf("s1_sec_e%0d", e + 1), sec_count, vecs[e].sec);
      chk($sformatf("s1_alarm_e%0d", e + 1), {31'd0, alarm}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'd0};
    vecs[7]  = '{1'b1, 1'b0, 32'd0};
    vecs[8]  = '{1'b1, 1'b0, 32'd0};
    vecs[9]  = '{1'b1, 1'b0, 32'd0};
    vecs[10] = '{1'b1, 1'b0, 32'd0};
    vecs[11] = '{1'b1, 1'b1, 32'd1};
    vecs[12] = '{1'b1, 1'b0, 32'd1};
    vecs[13] = '{1'b1, 1'b0, 32'd1};
    vecs[14] = '{1'b1, 1'b0, 32'd1};
    vecs[15] = '{1'b1, 1'b1, 32'd2};
    vecs[16] = '{1'b1, 1'b0, 32'd2};
    vecs[17] = '{1'b1, 1'b0, 32'd2};
    vecs[18] = '{1'b1, 1'b0, 32'd2};
    vecs[19] = '{1'b1, 1'b1, 32'd3};

    step(3);
    chk("rst_xok", {31'd0, xtal_ok}, 32'd0);
    chk("rst_tick", {31'd0, tick_1hz}, 32'd0);
    chk("rst_sec", sec_count, 32'd0);
    chk("rst_alarm", {31'd0, alarm}, 32'd0);
    rst_n = 1'b1;

    run_startup_table();

    // Load lands on the edge a tick is due; the tick is swallowed.
    step(3);
    chk("s2_pre_sec", sec_count, 32'd3);
    load(32'hFFFF_FFFE);
    chk("s2_load_tick", {31'd0, tick_1hz}, 32'd0);
    chk("s2_load_sec", sec_count, 32'hFFFF_FFFE);
    step(3);
    chk("s2_hold_sec", sec_count, 32'hFFFF_FFFE);
    step();
    chk("s2_t1_tick", {31'd0, tick_1hz}, 32'd1);
    chk("s2_t1_sec", sec_count, 32'hFFFF_FFFF);
    step(4);
    chk("s2_wrap_tick", {31'd0, tick_1hz}, 32'd1);
    chk("s2_wrap_sec", sec_count, 32'd0);

    alarm_en  = 1'b1;
    alarm_val = 32'd5;
    load(32'd3);
    chk("s3_load_sec", sec_count, 32'd3);
    step(4);
    chk("s3_sec4", sec_count, 32'd4);
    step(3);
    chk("s3_alarm_pre", {31'd0, alarm}, 32'd0);
    step();
    chk("s3_sec5", sec_count, 32'd5);
    chk("s3_alarm_set", {31'd0, alarm}, 32'd1);
    step(4);
    chk("s3_sec6", sec_count, 32'd6);
    chk("s3_alarm_hold", {31'd0, alarm}, 32'd1);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    chk("s3_alarm_clr", {31'd0, alarm}, 32'd0);

    load(32'd4);
    step(3);
    alarm_clr = 1'b1;
    step();
    chk("s4_sec5", sec_count, 32'd5);
    chk("s4_set_wins", {31'd0, alarm}, 32'd1);
    step();
    alarm_clr = 1'b0;
    chk("s4_clr", {31'd0, alarm}, 32'd0);
    alarm_en = 1'b0;
    load(32'd3);
    step(8);
    chk("s4_dis_sec5", sec_count, 32'd5);
    chk("s4_dis_alarm5", {31'd0, alarm}, 32'd0);
    step(4);
    chk("s4_dis_sec6", sec_count, 32'd6);
    chk("s4_dis_alarm6", {31'd0, alarm}, 32'd0);

    alarm_en  = 1'b1;
    alarm_val = 32'd9;
    load(32'd9);
    chk("s5_load_sec", sec_count, 32'd9);
    chk("s5_load_alarm", {31'd0, alarm}, 32'd0);
    step(4);
    chk("s5_sec10", sec_count, 32'd10);
    chk("s5_alarm10", {31'd0, alarm}, 32'd0);
    load(32'hFFFF_FFFF);
    step(36);
    chk("s5_sec8", sec_count, 32'd8);
    chk("s5_alarm8", {31'd0, alarm}, 32'd0);
    step(4);
    chk("s5_sec9", sec_count, 32'd9);
    chk("s5_alarm9", {31'd0, alarm}, 32'd1);

    load(32'd7);
    chk("s6_pre_sec", sec_count, 32'd7);
    chk("s6_pre_alarm", {31'd0, alarm}, 32'd1);
    step(2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_async_xok", {31'd0, xtal_ok}, 32'd0);
    chk("s6_async_tick", {31'd0, tick_1hz}, 32'd0);
    chk("s6_async_sec", sec_count, 32'd0);
    chk("s6_async_alarm", {31'd0, alarm}, 32'd0);
    alarm_en = 1'b0;
    step(3);
    rst_n = 1'b1;
    run_startup_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
